cluster_frame_serializer: RTL and testbench

CLUSTER_FRAME_SERIALIZER -- requirements
Module: cluster_frame_serializer

---
 rtl/cluster_frame_serializer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_cluster_frame_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_frame_serializer.sv
// cluster_frame_serializer
// Captures eight sorted cluster {cnt,adr} pairs on a load strobe and presents
// them two at a time over four consecutive clock4x cycles. Frames may follow
// back-to-back when the next load arrives in the last cycle of the current frame.
// Loads that arrive mid-frame are dropped and raise a sticky collision flag.
// Optional feature macro: CLUSTER_BXN_STAMP_EN adds a 12-bit bunch-crossing
// counter whose value stamps each frame on bxn. Without it, bxn is tied to 0
// and bc0 is ignored.

module cluster_frame_serializer #(
    parameter int unsigned MXADRBITS = 11,
    parameter int unsigned MXCNTBITS = 3
) (
    input  logic                           clock4x,
    input  logic                           reset,
    input  logic [MXADRBITS-1:0]           adr0,
    input  logic [MXADRBITS-1:0]           adr1,
    input  logic [MXADRBITS-1:0]           adr2,
    input  logic [MXADRBITS-1:0]           adr3,
    input  logic [MXADRBITS-1:0]           adr4,
    input  logic [MXADRBITS-1:0]           adr5,
    input  logic [MXADRBITS-1:0]           adr6,
    input  logic [MXADRBITS-1:0]           adr7,
    input  logic [MXCNTBITS-1:0]           cnt0,
    input  logic [MXCNTBITS-1:0]           cnt1,
    input  logic [MXCNTBITS-1:0]           cnt2,
    input  logic [MXCNTBITS-1:0]           cnt3,
    input  logic [MXCNTBITS-1:0]           cnt4,
    input  logic [MXCNTBITS-1:0]           cnt5,
    input  logic [MXCNTBITS-1:0]           cnt6,
    input  logic [MXCNTBITS-1:0]           cnt7,
    input  logic                           load,
    input  logic                           overflow_in,
    input  logic                           bc0,
    output logic [MXCNTBITS+MXADRBITS-1:0] word0,
    output logic [MXCNTBITS+MXADRBITS-1:0] word1,
    output logic                           valid0,
    output logic                           valid1,
    output logic                           frame_start,
    output logic [3:0]                     n_valid,
    output logic                           overflow,
    output logic [11:0]                    bxn,
    output logic                           collision
);

    localparam int unsigned WORDBITS = MXCNTBITS + MXADRBITS;
    localparam int unsigned NCLUST   = 8;
    localparam logic [MXADRBITS-1:0] ADR_INVALID = '1;
    localparam logic [WORDBITS-1:0]  WORD_IDLE   = {{MXCNTBITS{1'b0}}, ADR_INVALID};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        SEND1 = 3'd2,
        SEND2 = 3'd3,
        SEND3 = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic [MXADRBITS-1:0] adr_in [NCLUST];
    logic [MXCNTBITS-1:0] cnt_in [NCLUST];

    // Pair 0 is driven straight from the inputs, so only clusters 2..7 are held.
    logic [MXADRBITS-1:0] adr_q [2:7];
    logic [MXCNTBITS-1:0] cnt_q [2:7];

    logic                 accept;
    logic                 collide;
    logic [3:0]           in_count;
    logic [MXADRBITS-1:0] sel_adr0;
    logic [MXADRBITS-1:0] sel_adr1;
    logic [MXCNTBITS-1:0] sel_cnt0;
    logic [MXCNTBITS-1:0] sel_cnt1;
    logic                 sel_live;

    assign adr_in[0] = adr0;
    assign adr_in[1] = adr1;
    assign adr_in[2] = adr2;
    assign adr_in[3] = adr3;
    assign adr_in[4] = adr4;
    assign adr_in[5] = adr5;
    assign adr_in[6] = adr6;
    assign adr_in[7] = adr7;
    assign cnt_in[0] = cnt0;
    assign cnt_in[1] = cnt1;
    assign cnt_in[2] = cnt2;
    assign cnt_in[3] = cnt3;
    assign cnt_in[4] = cnt4;
    assign cnt_in[5] = cnt5;
    assign cnt_in[6] = cnt6;
    assign cnt_in[7] = cnt7;

    // Invalid clusters are always presented as cnt=0, adr=all-ones.
    function automatic logic [WORDBITS-1:0] make_word(
        input logic [MXADRBITS-1:0] a,
        input logic [MXCNTBITS-1:0] c
    );
        if (a == ADR_INVALID) begin
            return WORD_IDLE;
        end
        return {c, a};
    endfunction

    // Number of valid clusters on the inputs, latched into n_valid on accept.
    always_comb begin
        in_count = 4'd0;
        for (int i = 0; i < NCLUST; i++) begin
            if (adr_in[i] != ADR_INVALID) begin
                in_count = in_count + 4'd1;
            end
        end
    end

    // Next-state logic and selection of the pair to present after the edge.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        collide    = 1'b0;
        sel_adr0   = ADR_INVALID;
        sel_adr1   = ADR_INVALID;
        sel_cnt0   = '0;
        sel_cnt1   = '0;
        sel_live   = 1'b0;

        case (state)
            IDLE: begin
                if (load) begin
                    accept     = 1'b1;
                    next_state = SEND0;
                end
            end
            SEND0: begin
                collide    = load;
                next_state = SEND1;
            end
            SEND1: begin
                collide    = load;
                next_state = SEND2;
            end
            SEND2: begin
                collide    = load;
                next_state = SEND3;
            end
            SEND3: begin
                if (load) begin
                    accept     = 1'b1;
                    next_state = SEND0;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        case (next_state)
            SEND0: begin
                sel_adr0 = adr_in[0];
                sel_cnt0 = cnt_in[0];
                sel_adr1 = adr_in[1];
                sel_cnt1 = cnt_in[1];
                sel_live = 1'b1;
            end
            SEND1: begin
                sel_adr0 = adr_q[2];
                sel_cnt0 = cnt_q[2];
                sel_adr1 = adr_q[3];
                sel_cnt1 = cnt_q[3];
                sel_live = 1'b1;
            end
            SEND2: begin
                sel_adr0 = adr_q[4];
                sel_cnt0 = cnt_q[4];
                sel_adr1 = adr_q[5];
                sel_cnt1 = cnt_q[5];
                sel_live = 1'b1;
            end
            SEND3: begin
                sel_adr0 = adr_q[6];
                sel_cnt0 = cnt_q[6];
                sel_adr1 = adr_q[7];
                sel_cnt1 = cnt_q[7];
                sel_live = 1'b1;
            end
            default: begin
                sel_live = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock4x) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Cluster capture; written only on an accepting edge.
    always_ff @(posedge clock4x) begin
        if (!reset && accept) begin
            for (int i = 2; i < NCLUST; i++) begin
                adr_q[i] <= adr_in[i];
                cnt_q[i] <= cnt_in[i];
            end
        end
    end

    // Registered output pair and frame flags.
    always_ff @(posedge clock4x) begin
        if (reset) begin
            word0       <= WORD_IDLE;
            word1       <= WORD_IDLE;
            valid0      <= 1'b0;
            valid1      <= 1'b0;
            frame_start <= 1'b0;
            n_valid     <= 4'd0;
            overflow    <= 1'b0;
            collision   <= 1'b0;
        end else begin
            word0       <= make_word(sel_adr0, sel_cnt0);
            word1       <= make_word(sel_adr1, sel_cnt1);
            valid0      <= sel_live && (sel_adr0 != ADR_INVALID);
            valid1      <= sel_live && (sel_adr1 != ADR_INVALID);
            frame_start <= (next_state == SEND0);
            collision   <= collision | collide;
            if (accept) begin
                n_valid  <= in_count;
                overflow <= overflow_in;
            end else if (next_state == IDLE) begin
                n_valid  <= 4'd0;
                overflow <= 1'b0;
            end
        end
    end

`ifdef CLUSTER_BXN_STAMP_EN
    localparam logic [11:0] BX_LAST = 12'd3563;

    logic [11:0] bx_cnt;
    logic [11:0] bx_eff;
    logic [11:0] bxn_q;

    assign bx_eff = bc0 ? 12'd0 : bx_cnt;
    assign bxn    = bxn_q;

    // Bunch-crossing counter; bc0 on an accepted load restarts the count at 0.
    always_ff @(posedge clock4x) begin
        if (reset) begin
            bx_cnt <= 12'd0;
            bxn_q  <= 12'd0;
        end else if (accept) begin
            bxn_q  <= bx_eff;
            bx_cnt <= (bx_eff == BX_LAST) ? 12'd0 : bx_eff + 12'd1;
        end
    end
`else
    logic unused_bc0;

    assign unused_bc0 = bc0;
    assign bxn        = 12'd0;
`endif

endmodule

// File: tb/tb_cluster_frame_serializer.sv
// Directed bench for cluster_frame_serializer (default parameters).
module tb_cluster_frame_serializer;

    logic        clock4x = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] adr [8];
    logic [2:0]  cnt [8];
    logic        load        = 1'b0;
    logic        overflow_in = 1'b0;
    logic        bc0         = 1'b0;
    logic [13:0] word0, word1;
    logic        valid0, valid1, frame_start, overflow, collision;
    logic [3:0]  n_valid;
    logic [11:0] bxn;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus/model state
    logic [10:0] ta [8];
    logic [2:0]  tc [8];
    logic        tov;
    int          tb_bx    = 0;
    logic [11:0] last_bxn = 12'd0;
    logic        exp_col  = 1'b0;
    logic [13:0] obs_w0 [4];
    logic [13:0] obs_w1 [4];
    logic        obs_v1 [4];

    cluster_frame_serializer dut (
        .clock4x(clock4x), .reset(reset),
        .adr0(adr[0]), .adr1(adr[1]), .adr2(adr[2]), .adr3(adr[3]),
        .adr4(adr[4]), .adr5(adr[5]), .adr6(adr[6]), .adr7(adr[7]),
        .cnt0(cnt[0]), .cnt1(cnt[1]), .cnt2(cnt[2]), .cnt3(cnt[3]),
        .cnt4(cnt[4]), .cnt5(cnt[5]), .cnt6(cnt[6]), .cnt7(cnt[7]),
        .load(load), .overflow_in(overflow_in), .bc0(bc0),
        .word0(word0), .word1(word1), .valid0(valid0), .valid1(valid1),
        .frame_start(frame_start), .n_valid(n_valid), .overflow(overflow),
        .bxn(bxn), .collision(collision)
    );

    always #5 clock4x = ~clock4x;

    task automatic step();
        @(posedge clock4x);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] ew(input int i);
        if (ta[i] == 11'h7FF) return 14'h07FF;
        return {tc[i], ta[i]};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_w0"}, 32'(word0), 32'h7FF);
        chk({tag, "_w1"}, 32'(word1), 32'h7FF);
        chk({tag, "_v0"}, 32'(valid0), 32'd0);
        chk({tag, "_v1"}, 32'(valid1), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_nv"}, 32'(n_valid), 32'd0);
        chk({tag, "_ov"}, 32'(overflow), 32'd0);
        chk({tag, "_bxn"}, 32'(bxn), 32'(last_bxn));
        chk({tag, "_col"}, 32'(collision), 32'(exp_col));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        load  = 1'b0;
        step();
        tb_bx    = 0;
        last_bxn = 12'd0;
        exp_col  = 1'b0;
        chk_idle({tag, "_in"});
        reset = 1'b0;
        step();
        chk_idle({tag, "_out"});
    endtask

    // Accept one frame from ta/tc/tov and check all four pairs.
    // coll_at: pair index after which a stray load is driven (-1 none).
    // abort_at: pair index after which reset is applied (-1 none).
    task automatic run_frame(input string tag, input logic [3:0] exp_nv, input logic exp_ov,
                             input int coll_at, input int abort_at);
        int eb;
        logic pending;
        pending = 1'b0;
        for (int i = 0; i < 8; i++) begin
            adr[i] = ta[i];
            cnt[i] = tc[i];
        end
        overflow_in = tov;
        load = 1'b1;
        eb = bc0 ? 0 : tb_bx;
        tb_bx = (eb == 3563) ? 0 : eb + 1;
`ifdef CLUSTER_BXN_STAMP_EN
        last_bxn = 12'(eb);
`else
        last_bxn = 12'd0;
`endif
        step();
        load = 1'b0;
        bc0  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                step();
                load = 1'b0;
                if (pending) begin
                    exp_col = 1'b1;
                    pending = 1'b0;
                end
            end
            chk({tag, "_w0"}, 32'(word0), 32'(ew(2*k)));
            chk({tag, "_w1"}, 32'(word1), 32'(ew(2*k+1)));
            chk({tag, "_v0"}, 32'(valid0), 32'(ta[2*k] != 11'h7FF));
            chk({tag, "_v1"}, 32'(valid1), 32'(ta[2*k+1] != 11'h7FF));
            chk({tag, "_fs"}, 32'(frame_start), 32'(k == 0));
            chk({tag, "_nv"}, 32'(n_valid), 32'(exp_nv));
            chk({tag, "_ov"}, 32'(overflow), 32'(exp_ov));
            chk({tag, "_bxn"}, 32'(bxn), 32'(last_bxn));
            chk({tag, "_col"}, 32'(collision), 32'(exp_col));
            obs_w0[k] = word0;
            obs_w1[k] = word1;
            obs_v1[k] = valid1;
            if (k == coll_at) begin
                for (int i = 0; i < 8; i++) begin
                    adr[i] = 11'(i + 1);
                    cnt[i] = 3'd7;
                end
                overflow_in = 1'b1;
                load    = 1'b1;
                pending = 1'b1;
            end
            if (k == abort_at) begin
                do_reset({tag, "_abort"});
                return;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            adr[i] = 11'd0;
            cnt[i] = 3'd0;
        end

        // Reset state
        step();
        do_reset("reset");

        // Single frame: three valid clusters, invalid ones carry junk counts
        ta[0] = 11'd10;  ta[1] = 11'd20;  ta[2] = 11'd30;
        tc[0] = 3'd1;    tc[1] = 3'd2;    tc[2] = 3'd3;
        for (int i = 3; i < 8; i++) begin
            ta[i] = 11'h7FF;
            tc[i] = 3'd5;
        end
        tov = 1'b0;
        run_frame("single", 4'd3, 1'b0, -1, -1);
        chk("single_lit_p0w0", 32'(obs_w0[0]), 32'h080A);
        chk("single_lit_p0w1", 32'(obs_w1[0]), 32'h1014);
        chk("single_lit_p1w0", 32'(obs_w0[1]), 32'h181E);
        chk("single_lit_p1v1", 32'(obs_v1[1]), 32'd0);
        chk("single_lit_p3w1", 32'(obs_w1[3]), 32'h07FF);
        step();
        chk_idle("single_idle");

        // Back-to-back frames
        for (int i = 0; i < 8; i++) begin
            ta[i] = 11'(100 + 10 * i);
            tc[i] = 3'(i);
        end
        run_frame("b2b_a", 4'd8, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) begin
            ta[i] = (i < 5) ? 11'(500 + i) : 11'h7FF;
            tc[i] = 3'(7 - i);
        end
        tov = 1'b1;
        run_frame("b2b_b", 4'd5, 1'b1, -1, -1);
        for (int i = 0; i < 8; i++) begin
            ta[i] = (i < 2) ? 11'(1024 + i) : 11'h7FF;
            tc[i] = 3'd4;
        end
        tov = 1'b0;
        run_frame("b2b_c", 4'd2, 1'b0, -1, -1);
        step();
        chk_idle("b2b_idle");

        // Collision: stray load two cycles after the accept edge
        for (int i = 0; i < 8; i++) begin
            ta[i] = (i < 7) ? 11'(40 + i) : 11'h7FF;
            tc[i] = 3'(i + 1);
        end
        run_frame("coll", 4'd7, 1'b0, 1, -1);
        step();
        chk_idle("coll_idle");
        step();
        chk_idle("coll_sticky");
        do_reset("coll_clr");

        // Reset while SEND1 is on the outputs
        run_frame("abort", 4'd7, 1'b0, -1, 1);
        step();
        chk_idle("abort_after");

        // All clusters invalid with overflow set
        for (int i = 0; i < 8; i++) begin
            ta[i] = 11'h7FF;
            tc[i] = 3'd6;
        end
        tov = 1'b1;
        run_frame("ovf", 4'd0, 1'b1, -1, -1);
        step();
        chk_idle("ovf_idle");

`ifdef CLUSTER_BXN_STAMP_EN
        // BX stamp wraps 3563 -> 0
        for (int i = 0; i < 8; i++) begin
            ta[i] = 11'(i * 3);
            tc[i] = 3'd1;
        end
        tov = 1'b0;
        bc0 = 1'b1;
        run_frame("bx_first", 4'd8, 1'b0, -1, -1);
        chk("bx_first_zero", 32'(bxn), 32'd0);
        for (int n = 1; n <= 3564; n++) begin
            run_frame("bx", 4'd8, 1'b0, -1, -1);
            if (n == 3563) chk("bx_last", 32'(bxn), 32'd3563);
        end
        chk("bx_wrap", 32'(bxn), 32'd0);
        step();
        chk_idle("bx_idle");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
